instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch front end for the single-cycle MIPS core. It reads the byte-wide, big-endian instruction memory one byte per cycle and assembles 32-bit instruction words. Each completed word is queued together with its PC in a small FIFO. The core drains the FIFO with a valid/ready handshake, and a redirect from the branch/jump logic flushes all queued and in-flight fetches.

## Interface
- ADDR_W, 5, byte-address width of instruction memory (32 bytes); addresses wrap modulo 2^ADDR_W
- DEPTH, 4, queue entries; power of 2, minimum 2
- RESET_PC, 32'h0, fetch PC after reset; bits [1:0] must be 0

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  byte read request this cycle
- imem_addr  out  ADDR_W  byte address of the request
- imem_rdata  in  8  read byte, valid in the cycle after the request (fixed 1-cycle latency)
- inst  out  32  head instruction word
- inst_pc  out  32  PC of the head word
- inst_valid  out  1  queue non-empty
- inst_ready  in  1  core accepts the head word
- redirect  in  1  flush and refetch from redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] are ignored and treated as 0
- count  out  $clog2(DEPTH)+1  queued word count

## Operation
- fetch_pc is a 32-bit register holding the PC of the word being fetched, or of the next word to fetch.
- imem_addr is (fetch_pc + byte index)[ADDR_W-1:0]. Byte index 0 is the MSB byte (inst[31:24]); index 3 is inst[7:0].
- Request FSM states: WAIT, B1, B2, B3.
  - WAIT: if space is available, assert imem_req with byte index 0 and go to B1. Otherwise imem_req=0 and stay in WAIT.
  - B1, B2, B3: assert imem_req with byte index 1, 2, 3 respectively. B1→B2→B3 unconditionally, then B3→WAIT with fetch_pc += 4.
  - A word that has started always completes all 4 requests unless a redirect occurs.
- Space condition: registered count + pending < DEPTH.
  - pending = 1 from the byte-0 issue of a word until that word is pushed.
  - A pop in the same cycle does not create space until the next cycle.
- Response path: a 1-bit in-flight flag and a 2-bit index trail each request by one cycle.
  - Each returned byte shifts into a 32-bit assembly register.
  - When the byte with index 3 returns, {assembly[23:0], imem_rdata} is pushed with its PC.
- Queue: circular buffer with DEPTH entries and first-word fall-through.
  - inst and inst_pc show the head entry combinationally; they are 0 when the queue is empty.
  - inst_valid = (count != 0).
  - pop = inst_valid & inst_ready. Push and pop may occur in the same cycle; count is then unchanged.
- Redirect, synchronous and highest priority:
  - In the redirect cycle: imem_req=0, any returning byte is discarded, and a pop is ignored.
  - At the next edge: queue cleared (count=0), FSM→WAIT, pending=0, assembly cleared, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Fetch resumes in the following cycle.
- fetch_pc wraps naturally at 32 bits. Only its low ADDR_W bits reach memory.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC[ADDR_W-1:0]
  - inst=0, inst_pc=0, inst_valid=0, count=0
  - FSM=WAIT, fetch_pc=RESET_PC
- imem_req is forced 0 while rst_n is low.
- First cycle after reset release (cycle 0): byte 0 is requested.
  - Bytes are requested in cycles 0–3.
  - The last byte returns in cycle 4 and is pushed at the end of cycle 4.
  - inst_valid=1 in cycle 5.
- Throughput: with no backpressure, one word every 4 cycles. A WAIT in cycle 4 issues the next byte 0 if space exists.
- Full queue:
  - With DEPTH=4 and inst_ready=0, four words are queued and imem_req stays 0.
  - After one pop, byte 0 of the next word is issued in the cycle after the pop.
- Redirect to first instruction: a redirect in cycle r gives first request in r+1 and inst_valid in r+6.
- Asynchronous reset mid-word clears all state immediately. Partial words are lost.

## Test plan
- Cold start: mem[0..3]=8C,22,00,04 and inst_ready=0 → imem_addr 0,1,2,3 in cycles 0–3; inst_valid rises in cycle 5 with inst=32'h8C220004, inst_pc=0.
- Backpressure: inst_ready=0 for 30 cycles → count settles at 4, inst_pc=0; imem_req stays 0 from the cycle after pc 0x0C's byte 3. One pulse of inst_ready → count 4→3, then byte 0 for pc 0x10 is issued in the next cycle.
- Streaming/wrap: inst_ready=1 held → inst_pc 0,4,…,0x1C,0x20 every 4 cycles; pc 0x20 reads imem_addr 0..3 and returns the same word as pc 0.
- Redirect mid-word: redirect_pc=0x16 while byte 2 of pc 8 is requested → count=0 next cycle; requests at 0x14..0x17; first inst_pc=0x14 with no stale word.
- Simultaneous events: redirect with count=2, inst_ready=1, and byte 3 returning in the same cycle → no push, no pop, count=0; only redirect-target words appear afterwards.
- Async reset: drop rst_n mid-edge-interval during B2 with count=3 → inst_valid, count and imem_req go 0 immediately; after release, fetching restarts from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - byte-serial big-endian instruction fetch feeding a small word FIFO with redirect flush
module instr_fetch_queue #(
  parameter int          ADDR_W   = 5,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [7:0]               imem_rdata,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_WAIT, S_B1, S_B2, S_B3} state_t;

  state_t          state, state_nx;
  logic [31:0]     fetch_pc;
  logic            pending;
  logic            rsp_valid;
  logic [1:0]      rsp_idx;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_q;
  logic [31:0]     inst_q [DEPTH];
  logic [31:0]     pc_q   [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            space, req, issue0, push, pop;

  assign space = (count + {{PW{1'b0}}, pending}) < DEPTH_C;

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    byte_idx = 2'd0;
    case (state)
      S_WAIT: if (space) begin req = 1'b1; state_nx = S_B1; end
      S_B1:   begin req = 1'b1; byte_idx = 2'd1; state_nx = S_B2;   end
      S_B2:   begin req = 1'b1; byte_idx = 2'd2; state_nx = S_B3;   end
      S_B3:   begin req = 1'b1; byte_idx = 2'd3; state_nx = S_WAIT; end
      default: state_nx = S_WAIT;
    endcase
    if (redirect) begin
      req      = 1'b0;
      state_nx = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= state_nx;
  end

  assign issue0     = req & (state == S_WAIT);
  assign imem_req   = req & rst_n;
  assign imem_addr  = fetch_pc[ADDR_W-1:0] + ADDR_W'(byte_idx);
  assign push       = rsp_valid & (rsp_idx == 2'd3) & ~redirect;
  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready & ~redirect;
  assign inst       = inst_valid ? inst_q[rd_ptr] : 32'h0;
  assign inst_pc    = inst_valid ? pc_q[rd_ptr]   : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      pending   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_idx   <= 2'd0;
      asm_q     <= 24'h0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (redirect) begin
      fetch_pc  <= redirect_pc & ~32'd3;
      pending   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_idx   <= 2'd0;
      asm_q     <= 24'h0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      rsp_valid <= req;
      rsp_idx   <= byte_idx;
      if (state == S_B3) fetch_pc <= fetch_pc + 32'd4;
      if (issue0)        pending  <= 1'b1;
      else if (push)     pending  <= 1'b0;
      if (rsp_valid)     asm_q    <= {asm_q[15:0], imem_rdata};
      if (push)          wr_ptr   <= wr_ptr + 1'b1;
      if (pop)           rd_ptr   <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // fetch_pc already advanced past the word on its last request, so the pushed word sits 4 bytes back
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= {asm_q, imem_rdata};
      pc_q[wr_ptr]   <= fetch_pc - 32'd4;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed and randomized checks of instr_fetch_queue against a word-stream model
module tb_instr_fetch_queue;
  localparam int          ADDR_W   = 5;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   imem_req;
  logic [ADDR_W-1:0]      imem_addr;
  logic [7:0]             imem_rdata;
  logic [31:0]            inst, inst_pc;
  logic                   inst_valid;
  logic                   inst_ready = 1'b0;
  logic                   redirect = 1'b0;
  logic [31:0]            redirect_pc = 32'h0;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [32];

  instr_fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem_req ? mem[imem_addr] : 8'hEE;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    a0 = pc[ADDR_W-1:0];
    a1 = a0 + 5'd1;
    a2 = a0 + 5'd2;
    a3 = a0 + 5'd3;
    return {mem[a0], mem[a1], mem[a2], mem[a3]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", imem_req); end
    checks++; if (imem_addr !== RESET_PC[ADDR_W-1:0]) begin errors++; $display("FAIL rst_addr got %0h exp %0h", imem_addr, RESET_PC[ADDR_W-1:0]); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_inst got %0h exp 0", inst); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc got %0h exp 0", inst_pc); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", inst_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
  endtask

  task automatic test_cold_start();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c < 4) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 5'(c)) begin
          errors++; $display("FAIL cold_req c=%0d got req=%0b addr=%0h exp req=1 addr=%0h", c, imem_req, imem_addr, c);
        end
      end
      if (c == 4) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL cold_early_valid got %0b exp 0", inst_valid); end
      end
      if (c == 5) begin
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h8C220004 || inst_pc !== 32'h0) begin
          errors++; $display("FAIL cold_word got v=%0b inst=%h pc=%h exp v=1 inst=8c220004 pc=0", inst_valid, inst, inst_pc);
        end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    for (int c = 6; c < 36; c++) begin
      #1;
      if (c == 15) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 5'h0F) begin
          errors++; $display("FAIL bp_last_byte got req=%0b addr=%0h exp req=1 addr=f", imem_req, imem_addr);
        end
      end
      if (c >= 16 && imem_req !== 1'b0) bad++;
      cyc();
    end
    #1;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_req_idle got %0d busy cycles exp 0", bad); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL bp_full_count got %0d exp 4", count); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc got %h exp 0", inst_pc); end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL bp_pop_count got %0d exp 3", count); end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 5'h10) begin
      errors++; $display("FAIL bp_refill got req=%0b addr=%0h exp req=1 addr=10", imem_req, imem_addr);
    end
    checks++;
    if (inst_pc !== 32'h4 || inst !== word_at(32'h4)) begin
      errors++; $display("FAIL bp_next_head got pc=%h inst=%h exp pc=4 inst=%h", inst_pc, inst, word_at(32'h4));
    end
  endtask

  task automatic test_stream();
    int n;
    n = 0;
    do_reset();
    inst_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (c >= 32 && c < 36) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 5'(c - 32)) begin
          errors++; $display("FAIL stream_wrap_addr c=%0d got addr=%0h exp %0h", c, imem_addr, c - 32);
        end
      end
      if (inst_valid) begin
        checks++;
        if (inst_pc !== 32'(4 * n) || inst !== word_at(32'(4 * n)) || c != 4 * n + 5) begin
          errors++; $display("FAIL stream_word n=%0d got pc=%h inst=%h cyc=%0d exp pc=%h inst=%h cyc=%0d",
                             n, inst_pc, inst, c, 4 * n, word_at(32'(4 * n)), 4 * n + 5);
        end
        if (n == 8) begin
          checks++; if (inst !== 32'h8C220004) begin errors++; $display("FAIL stream_wrap_word got %h exp 8c220004", inst); end
        end
        n++;
      end
      cyc();
    end
    checks++; if (n != 12) begin errors++; $display("FAIL stream_count got %0d exp 12", n); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_mid();
    do_reset();
    for (int c = 0; c < 18; c++) begin
      redirect    = (c == 10);
      redirect_pc = 32'h16;
      #1;
      if (c == 10) begin
        checks++;
        if (count !== 3'd2 || imem_req !== 1'b0) begin
          errors++; $display("FAIL redir_cycle got count=%0d req=%0b exp count=2 req=0", count, imem_req);
        end
      end
      if (c == 11) begin
        checks++;
        if (count !== '0 || inst_valid !== 1'b0) begin
          errors++; $display("FAIL redir_flush got count=%0d valid=%0b exp 0 0", count, inst_valid);
        end
      end
      if (c >= 11 && c <= 14) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 5'(5'h14 + c - 11)) begin
          errors++; $display("FAIL redir_addr c=%0d got req=%0b addr=%0h exp req=1 addr=%0h", c, imem_req, imem_addr, 5'h14 + c - 11);
        end
      end
      if (c == 15) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_stale got valid=%0b pc=%h exp 0", inst_valid, inst_pc); end
      end
      if (c == 16) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h14 || inst !== word_at(32'h14)) begin
          errors++; $display("FAIL redir_first got v=%0b pc=%h inst=%h exp v=1 pc=14 inst=%h", inst_valid, inst_pc, inst, word_at(32'h14));
        end
      end
      cyc();
    end
    redirect = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [31:0] raw, exp_pc;
    int npop;
    npop = 0;
    raw  = $urandom;
    exp_pc = raw & ~32'd3;
    do_reset();
    repeat (12) cyc();
    redirect = 1'b1; redirect_pc = raw; inst_ready = 1'b1;
    #1;
    checks++;
    if (count !== 3'd2 || inst_valid !== 1'b1) begin
      errors++; $display("FAIL simul_pre got count=%0d valid=%0b exp 2 1", count, inst_valid);
    end
    cyc();
    redirect = 1'b0; inst_ready = 1'b0;
    #1;
    checks++;
    if (count !== '0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL simul_flush got count=%0d valid=%0b exp 0 0", count, inst_valid);
    end
    inst_ready = 1'b1;
    for (int c = 13; c < 53; c++) begin
      #1;
      if (inst_valid) begin
        checks++;
        if (inst_pc !== exp_pc || inst !== word_at(exp_pc)) begin
          errors++; $display("FAIL simul_word got pc=%h inst=%h exp pc=%h inst=%h", inst_pc, inst, exp_pc, word_at(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        npop++;
      end
      cyc();
    end
    checks++; if (npop != 9) begin errors++; $display("FAIL simul_pops got %0d exp 9", npop); end
    inst_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (14) cyc();
    #1;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_pre got count=%0d exp 3", count); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || count !== '0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL areset_now got valid=%0b count=%0d req=%0b exp 0 0 0", inst_valid, count, imem_req);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c < 4) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 5'(RESET_PC[ADDR_W-1:0] + c)) begin
          errors++; $display("FAIL areset_refetch c=%0d got req=%0b addr=%0h exp req=1 addr=%0h", c, imem_req, imem_addr, c);
        end
      end
      if (c == 5) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== word_at(RESET_PC)) begin
          errors++; $display("FAIL areset_word got v=%0b pc=%h inst=%h exp v=1 pc=%h inst=%h", inst_valid, inst_pc, inst, RESET_PC, word_at(RESET_PC));
        end
      end
      cyc();
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int npop, inv_bad;
    npop = 0; inv_bad = 0;
    exp_pc = RESET_PC;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      inst_ready  = ($urandom_range(0, 1) == 1);
      redirect    = ($urandom_range(0, 39) == 0);
      redirect_pc = $urandom;
      #1;
      if (count > DEPTH || inst_valid !== (count != '0)) inv_bad++;
      if (redirect) begin
        exp_pc = redirect_pc & ~32'd3;
      end else if (inst_valid && inst_ready) begin
        checks++;
        if (inst_pc !== exp_pc || inst !== word_at(exp_pc)) begin
          errors++; $display("FAIL rand_word c=%0d got pc=%h inst=%h exp pc=%h inst=%h", c, inst_pc, inst, exp_pc, word_at(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        npop++;
      end
      cyc();
    end
    redirect = 1'b0; inst_ready = 1'b0;
    checks++; if (inv_bad != 0) begin errors++; $display("FAIL rand_count_rules got %0d bad cycles exp 0", inv_bad); end
    checks++; if (npop < 50) begin errors++; $display("FAIL rand_progress got %0d pops exp at least 50", npop); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h8C; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h04;
    test_reset();
    test_cold_start();
    test_backpressure();
    test_stream();
    test_redirect_mid();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
